seq_event_monitor: RTL and testbench

SEQ_EVENT_MONITOR -- requirements
Module: seq_event_monitor

---
 rtl/seq_mon_pkg.sv | 32 +++
 rtl/seq_window_timer.sv | 51 +++++
 rtl/seq_event_monitor.sv | 164 ++++++++++++++++
 tb/tb_seq_event_monitor.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mon_pkg
//  Description : Shared widths, FSM state encoding and the saturating
//                increment helper for the sequence event monitor.
//  Revision    : 1.0  initial release
// ============================================================================
package seq_mon_pkg;

    localparam int COUNT_W = 8;
    localparam int TIMER_W = 16;

    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mon_state_e;

    // Add one detection to a count, holding at COUNT_MAX instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value,
                                                   input logic                inc);
        logic [COUNT_W-1:0] result;
        result = value;
        if (inc && (value != COUNT_MAX)) begin
            result = value + 1'b1;
        end
        return result;
    endfunction

endpackage : seq_mon_pkg
`default_nettype wire

// File: rtl/seq_window_timer.sv
`default_nettype none
// ============================================================================
//  Module      : seq_window_timer
//  Description : Window down-counter. Loads LOAD_VAL, decrements on request
//                and flags when it has reached zero. Synchronous clear wins
//                over load, load wins over decrement.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_window_timer
    import seq_mon_pkg::*;
#(
    parameter int unsigned LOAD_VAL = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic timer_clr,
    input  logic timer_load,
    input  logic timer_dec,
    output logic timer_zero
);

    localparam logic [TIMER_W-1:0] LOAD_VAL_C = TIMER_W'(LOAD_VAL);

    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;

    // Next timer value: clear, reload, or count down without underflowing.
    always_comb begin
        timer_d = timer_q;
        if (timer_clr) begin
            timer_d = '0;
        end else if (timer_load) begin
            timer_d = LOAD_VAL_C;
        end else if (timer_dec && (timer_q != '0)) begin
            timer_d = timer_q - 1'b1;
        end
    end

    // Timer register with asynchronous reset to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timer_zero = (timer_q == '0);

endmodule : seq_window_timer
`default_nettype wire

// File: rtl/seq_event_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : seq_event_monitor
//  Description : Counts upstream detections over back-to-back windows of
//                WINDOW_LEN cycles, publishes each closed window's count with
//                a valid/ack handshake, raises alarm when the count reaches
//                THRESH, and keeps sticky saturation and overrun flags.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_event_monitor
    import seq_mon_pkg::*;
#(
    parameter int unsigned WINDOW_LEN = 16,
    parameter int unsigned THRESH     = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               detect_in,
    input  logic               enable,
    input  logic               clear,
    input  logic               result_ack,
    output logic [COUNT_W-1:0] result_count,
    output logic               result_valid,
    output logic               alarm,
    output logic               sat_flag,
    output logic               overrun
);

    localparam logic [COUNT_W-1:0] THRESH_C = COUNT_W'(THRESH);

    mon_state_e         state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] result_count_q, result_count_d;
    logic               result_valid_q, result_valid_d;
    logic               alarm_q, alarm_d;
    logic               sat_flag_q, sat_flag_d;
    logic               overrun_q, overrun_d;

    logic               timer_clr;
    logic               timer_load;
    logic               timer_dec;
    logic               timer_zero;

    // Count including the current cycle's detection, and whether that
    // detection is the one that would have taken the count past its maximum.
    logic [COUNT_W-1:0] count_next;
    logic               sat_hit;

    assign count_next = sat_inc(count_q, detect_in);
    assign sat_hit    = detect_in && (count_q == COUNT_MAX);

    seq_window_timer #(
        .LOAD_VAL (WINDOW_LEN - 1)
    ) u_window_timer (
        .clock      (clock),
        .reset      (reset),
        .timer_clr  (timer_clr),
        .timer_load (timer_load),
        .timer_dec  (timer_dec),
        .timer_zero (timer_zero)
    );

    // Next-state, window accounting and result handshake.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        result_count_d = result_count_q;
        result_valid_d = result_valid_q;
        alarm_d        = alarm_q;
        sat_flag_d     = sat_flag_q;
        overrun_d      = overrun_q;
        timer_clr      = 1'b0;
        timer_load     = 1'b0;
        timer_dec      = 1'b0;

        if (clear) begin
            state_d        = IDLE;
            count_d        = '0;
            result_count_d = '0;
            result_valid_d = 1'b0;
            alarm_d        = 1'b0;
            sat_flag_d     = 1'b0;
            overrun_d      = 1'b0;
            timer_clr      = 1'b1;
        end else begin
            // Consumer takes the held result; a window closing this same
            // cycle re-asserts valid below.
            if (result_valid_q && result_ack) begin
                result_valid_d = 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_d    = RUN;
                        count_d    = '0;
                        timer_load = 1'b1;
                    end
                end

                RUN: begin
                    if (!enable) begin
                        // Abort: the partial window is thrown away, the held
                        // result and sticky flags are left alone.
                        state_d   = IDLE;
                        count_d   = '0;
                        timer_clr = 1'b1;
                    end else begin
                        if (sat_hit) begin
                            sat_flag_d = 1'b1;
                        end

                        if (timer_zero) begin
                            result_count_d = count_next;
                            alarm_d        = (count_next >= THRESH_C);
                            result_valid_d = 1'b1;
                            if (result_valid_q && !result_ack) begin
                                overrun_d = 1'b1;
                            end
                            count_d    = '0;
                            timer_load = 1'b1;
                        end else begin
                            count_d   = count_next;
                            timer_dec = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            count_q        <= '0;
            result_count_q <= '0;
            result_valid_q <= 1'b0;
            alarm_q        <= 1'b0;
            sat_flag_q     <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            result_count_q <= result_count_d;
            result_valid_q <= result_valid_d;
            alarm_q        <= alarm_d;
            sat_flag_q     <= sat_flag_d;
            overrun_q      <= overrun_d;
        end
    end

    assign result_count = result_count_q;
    assign result_valid = result_valid_q;
    assign alarm        = alarm_q;
    assign sat_flag     = sat_flag_q;
    assign overrun      = overrun_q;

endmodule : seq_event_monitor
`default_nettype wire

// File: tb/tb_seq_event_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_event_monitor
//  Description : Directed self-checking bench for seq_event_monitor. A small
//                1011 Moore detector feeds the monitor for the bit-pattern
//                case; other cases force detect_in directly. A second
//                instance with a 300-cycle window covers saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_event_monitor;
    import seq_mon_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       clear;
    logic       result_ack;
    logic       use_det;
    logic       det_force;
    logic       bit_in;
    logic       detect_in;
    logic [7:0] result_count;
    logic       result_valid;
    logic       alarm;
    logic       sat_flag;
    logic       overrun;

    logic       s_enable;
    logic       s_detect;
    logic       s_clear;
    logic       s_ack;
    logic [7:0] s_result_count;
    logic       s_result_valid;
    logic       s_alarm;
    logic       s_sat_flag;
    logic       s_overrun;

    int checks = 0;
    int errors = 0;

    logic [10:0] pat;

    always #5 clock = ~clock;

    // Upstream 1011 Moore detector (overlapping): state 4 means "1011 seen".
    logic [2:0] det_st;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            det_st <= 3'd0;
        end else begin
            case (det_st)
                3'd0:    det_st <= bit_in ? 3'd1 : 3'd0;
                3'd1:    det_st <= bit_in ? 3'd1 : 3'd2;
                3'd2:    det_st <= bit_in ? 3'd3 : 3'd0;
                3'd3:    det_st <= bit_in ? 3'd4 : 3'd2;
                3'd4:    det_st <= bit_in ? 3'd1 : 3'd2;
                default: det_st <= 3'd0;
            endcase
        end
    end

    assign detect_in = use_det ? (det_st == 3'd4) : det_force;

    seq_event_monitor #(
        .WINDOW_LEN (16),
        .THRESH     (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .detect_in    (detect_in),
        .enable       (enable),
        .clear        (clear),
        .result_ack   (result_ack),
        .result_count (result_count),
        .result_valid (result_valid),
        .alarm        (alarm),
        .sat_flag     (sat_flag),
        .overrun      (overrun)
    );

    seq_event_monitor #(
        .WINDOW_LEN (300),
        .THRESH     (3)
    ) dut_sat (
        .clock        (clock),
        .reset        (reset),
        .detect_in    (s_detect),
        .enable       (s_enable),
        .clear        (s_clear),
        .result_ack   (s_ack),
        .result_count (s_result_count),
        .result_valid (s_result_valid),
        .alarm        (s_alarm),
        .sat_flag     (s_sat_flag),
        .overrun      (s_overrun)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_count"},   int'(result_count), 0);
        chk({tag, "_valid"},   int'(result_valid), 0);
        chk({tag, "_alarm"},   int'(alarm), 0);
        chk({tag, "_sat"},     int'(sat_flag), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        clear      = 1'b0;
        result_ack = 1'b0;
        use_det    = 1'b0;
        det_force  = 1'b0;
        bit_in     = 1'b0;
        s_enable   = 1'b0;
        s_detect   = 1'b0;
        s_clear    = 1'b0;
        s_ack      = 1'b0;
        pat        = 11'b10110110111;

        // Reset state
        #2;
        chk_all_zero("reset");
        chk("reset_state", int'(dut.state_q), int'(IDLE));
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("post_reset_state", int'(dut.state_q), int'(IDLE));

        // Bit stream 10110110111 through the detector: 3 detections
        use_det = 1'b1;
        enable  = 1'b1;
        tick(1);
        for (int i = 0; i < 16; i++) begin
            bit_in = (i < 11) ? pat[10-i] : 1'b0;
            tick(1);
            if (i == 14) chk("pat_valid_before_close", int'(result_valid), 0);
        end
        chk("pat_valid", int'(result_valid), 1);
        chk("pat_count", int'(result_count), 3);
        chk("pat_alarm", int'(alarm), 1);
        chk("pat_overrun", int'(overrun), 0);
        bit_in  = 1'b0;
        use_det = 1'b0;

        // Abort keeps the held result
        enable = 1'b0;
        tick(1);
        chk("abort_state", int'(dut.state_q), int'(IDLE));
        chk("abort_hold_valid", int'(result_valid), 1);
        chk("abort_hold_count", int'(result_count), 3);

        // Clear with a result pending
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk_all_zero("clear");
        chk("clear_state", int'(dut.state_q), int'(IDLE));

        // Two detections: below threshold
        enable = 1'b1;
        tick(1);
        for (int i = 0; i < 16; i++) begin
            det_force = (i == 3) || (i == 7);
            tick(1);
        end
        chk("two_count", int'(result_count), 2);
        chk("two_alarm", int'(alarm), 0);
        chk("two_valid", int'(result_valid), 1);
        chk("two_overrun", int'(overrun), 0);

        // Second window without ack: overwrite and overrun
        for (int i = 0; i < 16; i++) begin
            det_force = (i < 4);
            tick(1);
        end
        chk("ovr_count", int'(result_count), 4);
        chk("ovr_alarm", int'(alarm), 1);
        chk("ovr_valid", int'(result_valid), 1);
        chk("ovr_overrun", int'(overrun), 1);
        chk("ovr_sat", int'(sat_flag), 0);
        det_force = 1'b0;
        enable    = 1'b0;
        tick(1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("ovr_cleared", int'(overrun), 0);

        // Ack coincident with window close: no overrun
        enable = 1'b1;
        tick(1);
        for (int i = 0; i < 16; i++) begin
            det_force = (i == 0);
            tick(1);
        end
        chk("ackA_count", int'(result_count), 1);
        chk("ackA_alarm", int'(alarm), 0);
        for (int i = 0; i < 16; i++) begin
            det_force  = (i == 2) || (i == 4) || (i == 6);
            result_ack = (i == 15);
            tick(1);
        end
        chk("ackB_valid", int'(result_valid), 1);
        chk("ackB_count", int'(result_count), 3);
        chk("ackB_alarm", int'(alarm), 1);
        chk("ackB_overrun", int'(overrun), 0);
        det_force  = 1'b0;
        result_ack = 1'b1;
        tick(1);
        chk("ack_clears_valid", int'(result_valid), 0);
        tick(1);
        chk("ack_idle_valid", int'(result_valid), 0);
        chk("ack_idle_overrun", int'(overrun), 0);
        result_ack = 1'b0;
        enable     = 1'b0;
        tick(1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;

        // Enable dropped at cycle 5 of a window: no result
        enable = 1'b1;
        tick(1);
        det_force = 1'b1;
        tick(5);
        enable = 1'b0;
        tick(1);
        chk("drop_state", int'(dut.state_q), int'(IDLE));
        det_force = 1'b0;
        tick(20);
        chk("drop_valid", int'(result_valid), 0);
        chk("drop_count", int'(result_count), 0);

        // Reset mid-window with a result held
        enable = 1'b1;
        tick(1);
        for (int i = 0; i < 16; i++) begin
            det_force = (i < 3);
            tick(1);
        end
        chk("pre_rst_valid", int'(result_valid), 1);
        det_force = 1'b1;
        tick(8);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", int'(result_valid), 0);
        chk("async_rst_count", int'(result_count), 0);
        chk("async_rst_alarm", int'(alarm), 0);
        chk("async_rst_state", int'(dut.state_q), int'(IDLE));
        enable    = 1'b0;
        det_force = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(20);
        chk("post_rst_valid", int'(result_valid), 0);
        chk("post_rst_state", int'(dut.state_q), int'(IDLE));

        // Saturation over a 300-cycle window
        s_enable = 1'b1;
        tick(1);
        s_detect = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (i == 254) chk("sat_before_256th", int'(s_sat_flag), 0);
            if (i == 255) chk("sat_at_256th", int'(s_sat_flag), 1);
            if (i == 298) chk("sat_valid_before_close", int'(s_result_valid), 0);
        end
        chk("sat_count", int'(s_result_count), 255);
        chk("sat_valid", int'(s_result_valid), 1);
        chk("sat_alarm", int'(s_alarm), 1);
        chk("sat_flag", int'(s_sat_flag), 1);
        s_detect = 1'b0;
        s_enable = 1'b0;
        tick(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_event_monitor
`default_nettype wire
